// File: rtl/control_unit_fsm.sv
// Multicycle control sequencer: fetches and decodes 8-bit instructions, drives the
// register-file addresses and ALU op, and owns the program and retired-instruction counters.
module control_unit_fsm #(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_imem_valid,
  input  logic [7:0]           i_imem_data,
  input  logic                 i_alu_zero,
  output logic                 o_imem_req,
  output logic [PC_WIDTH-1:0]  o_imem_addr,
  output logic [1:0]           o_rd_addr,
  output logic [1:0]           o_rs_addr,
  output logic [1:0]           o_alu_op,
  output logic                 o_reg_we,
  output logic                 o_zero_flag,
  output logic [PC_WIDTH-1:0]  o_pc,
  output logic                 o_busy,
  output logic                 o_halted,
  output logic [CNT_WIDTH-1:0] o_retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALTED
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                r_state, w_nextState;
  logic [PC_WIDTH-1:0]   r_pc, w_nextPc;
  logic [7:0]            r_ir, w_nextIr;
  logic [1:0]            r_rdAddr, w_nextRdAddr;
  logic [1:0]            r_rsAddr, w_nextRsAddr;
  logic [1:0]            r_aluOp, w_nextAluOp;
  logic                  r_zeroFlag, w_nextZeroFlag;
  logic [CNT_WIDTH-1:0]  r_retired, w_nextRetired;
  logic                  w_retire;
  logic                  w_unusedIrBit;

  assign w_unusedIrBit = r_ir[0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_ir       <= '0;
      r_rdAddr   <= '0;
      r_rsAddr   <= '0;
      r_aluOp    <= '0;
      r_zeroFlag <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state    <= w_nextState;
      r_pc       <= w_nextPc;
      r_ir       <= w_nextIr;
      r_rdAddr   <= w_nextRdAddr;
      r_rsAddr   <= w_nextRsAddr;
      r_aluOp    <= w_nextAluOp;
      r_zeroFlag <= w_nextZeroFlag;
      r_retired  <= w_nextRetired;
    end
  end

  // ir[7]=0 selects the four ALU ops directly; ir[7]=1 splits into BEQ, HALT and NOP.
  always_comb begin
    w_nextState    = r_state;
    w_nextPc       = r_pc;
    w_nextIr       = r_ir;
    w_nextRdAddr   = r_rdAddr;
    w_nextRsAddr   = r_rsAddr;
    w_nextAluOp    = r_aluOp;
    w_nextZeroFlag = r_zeroFlag;
    w_retire       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_nextState = S_FETCH;
      end
      S_FETCH: begin
        if (i_imem_valid) begin
          w_nextIr    = i_imem_data;
          w_nextState = S_DECODE;
        end
      end
      S_DECODE: begin
        w_nextRdAddr = r_ir[4:3];
        w_nextRsAddr = r_ir[2:1];
        if (!r_ir[7]) begin
          w_nextAluOp = r_ir[6:5];
          w_nextState = S_EXECUTE;
        end else if (r_ir[6:5] == 2'b00) begin
          w_nextAluOp = 2'b01;
          w_nextState = S_EXECUTE;
        end else if (r_ir[6:5] == 2'b01) begin
          w_retire    = 1'b1;
          w_nextState = S_HALTED;
        end else begin
          w_nextPc    = r_pc + PC_WIDTH'(1);
          w_retire    = 1'b1;
          w_nextState = S_FETCH;
        end
      end
      S_EXECUTE: begin
        w_nextZeroFlag = i_alu_zero;
        if (r_ir[7]) begin
          w_nextPc    = r_pc + (i_alu_zero ? PC_WIDTH'(2) : PC_WIDTH'(1));
          w_retire    = 1'b1;
          w_nextState = S_FETCH;
        end else begin
          w_nextState = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        w_nextPc    = r_pc + PC_WIDTH'(1);
        w_retire    = 1'b1;
        w_nextState = S_FETCH;
      end
      S_HALTED: begin
        if (i_start) begin
          w_nextPc    = '0;
          w_nextState = S_FETCH;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
    w_nextRetired = r_retired;
    if (w_retire && (r_retired != CNT_MAX)) w_nextRetired = r_retired + CNT_WIDTH'(1);
  end

  assign o_imem_req  = (r_state == S_FETCH);
  assign o_imem_addr = r_pc;
  assign o_rd_addr   = r_rdAddr;
  assign o_rs_addr   = r_rsAddr;
  assign o_alu_op    = r_aluOp;
  assign o_reg_we    = (r_state == S_WRITEBACK);
  assign o_zero_flag = r_zeroFlag;
  assign o_pc        = r_pc;
  assign o_busy      = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                       (r_state == S_EXECUTE) || (r_state == S_WRITEBACK);
  assign o_halted    = (r_state == S_HALTED);
  assign o_retired   = r_retired;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Scoreboard bench for control_unit_fsm: stimulus pushes per-instruction expectations,
// a negedge monitor pops and compares them whenever an instruction completes.
module tb_control_unit_fsm;

  logic        clk = 1'b0;
  logic        rst, start, imemValid, aluZero;
  logic [7:0]  imemData;
  logic        imemReq, regWe, zeroFlag, busy, halted;
  logic [7:0]  imemAddr, pc;
  logic [1:0]  rdAddr, rsAddr, aluOp;
  logic [15:0] retired;

  logic        unusedReq2, unusedWe2, unusedZf2, unusedBusy2, unusedHalted2;
  logic [7:0]  unusedAddr2, unusedPc2;
  logic [1:0]  unusedRd2, unusedRs2, unusedOp2;
  logic [1:0]  retired2;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] retired;
    logic        zf;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [1:0]  op;
    int          we;
    int          lat;
    logic        halted;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  bit   inFlight = 1'b0;
  int   lat = 0;
  int   weCount = 0;

  always #5 clk = ~clk;

  control_unit_fsm #(.PC_WIDTH(8), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_imem_valid(imemValid),
    .i_imem_data(imemData), .i_alu_zero(aluZero),
    .o_imem_req(imemReq), .o_imem_addr(imemAddr), .o_rd_addr(rdAddr),
    .o_rs_addr(rsAddr), .o_alu_op(aluOp), .o_reg_we(regWe),
    .o_zero_flag(zeroFlag), .o_pc(pc), .o_busy(busy), .o_halted(halted),
    .o_retired(retired)
  );

  // Narrow counter copy running the same program, used only to see saturation.
  control_unit_fsm #(.PC_WIDTH(8), .CNT_WIDTH(2)) dutSat (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_imem_valid(imemValid),
    .i_imem_data(imemData), .i_alu_zero(aluZero),
    .o_imem_req(unusedReq2), .o_imem_addr(unusedAddr2), .o_rd_addr(unusedRd2),
    .o_rs_addr(unusedRs2), .o_alu_op(unusedOp2), .o_reg_we(unusedWe2),
    .o_zero_flag(unusedZf2), .o_pc(unusedPc2), .o_busy(unusedBusy2),
    .o_halted(unusedHalted2), .o_retired(retired2)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] p, input logic [15:0] r, input logic z,
                              input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] op,
                              input int we, input int lt, input logic h);
    exp_t e;
    e.pc = p; e.retired = r; e.zf = z; e.rd = rd; e.rs = rs; e.op = op;
    e.we = we; e.lat = lt; e.halted = h;
    return e;
  endfunction

  // An instruction completes at the first FETCH or HALTED cycle after its fetch was accepted.
  always @(negedge clk) begin
    if (rst) begin
      inFlight = 1'b0;
      weCount  = 0;
    end else begin
      if (inFlight && (imemReq || halted)) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected completion", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("pc", 32'(pc), 32'(e.pc));
          checkOutput("retired", 32'(retired), 32'(e.retired));
          checkOutput("zero_flag", 32'(zeroFlag), 32'(e.zf));
          checkOutput("rd_addr", 32'(rdAddr), 32'(e.rd));
          checkOutput("rs_addr", 32'(rsAddr), 32'(e.rs));
          checkOutput("alu_op", 32'(aluOp), 32'(e.op));
          checkOutput("reg_we pulses", 32'(weCount), 32'(e.we));
          checkOutput("latency", 32'(lat), 32'(e.lat));
          checkOutput("halted", 32'(halted), 32'(e.halted));
        end
        inFlight = 1'b0;
      end
      if (imemReq && imemValid) begin
        inFlight = 1'b1;
        lat      = 1;
        weCount  = 0;
      end else if (inFlight) begin
        lat++;
      end
      if (regWe) weCount++;
    end
  end

  task automatic applyStimulus(input logic [7:0] instr, input logic zero, input bit pulseStart, input exp_t e);
    int n;
    expQ.push_back(e);
    aluZero = zero;
    n = 0;
    while (!imemReq && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!imemReq) checkOutput("fetch wait timeout", 32'd0, 32'd1);
    imemData  = instr;
    imemValid = 1'b1;
    @(posedge clk); #1;
    imemValid = 1'b0;
    imemData  = 8'hA0;
    if (pulseStart) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    n = 0;
    while (!(imemReq || halted) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(imemReq || halted)) checkOutput("completion timeout", 32'd0, 32'd1);
  endtask

  task automatic pulseStartOnce();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  p;
    logic [15:0] r;
    int          n;
    rst = 1'b1; start = 1'b0; imemValid = 1'b0; imemData = 8'h00; aluZero = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset pc", 32'(pc), 32'd0);
    checkOutput("reset imem_req", 32'(imemReq), 32'd0);
    checkOutput("reset reg_we", 32'(regWe), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset halted", 32'(halted), 32'd0);
    checkOutput("reset retired", 32'(retired), 32'd0);
    checkOutput("reset alu_op", 32'(aluOp), 32'd0);
    @(posedge clk); #1;
    checkOutput("idle holds without start", 32'(imemReq), 32'd0);
    pulseStartOnce();
    checkOutput("start enters fetch", 32'(imemReq), 32'd1);

    applyStimulus(8'h0A, 1'b0, 1'b1, mk(8'd1, 16'd1, 1'b0, 2'd1, 2'd1, 2'd0, 1, 4, 1'b0));
    applyStimulus(8'h3C, 1'b1, 1'b0, mk(8'd2, 16'd2, 1'b1, 2'd3, 2'd2, 2'd1, 1, 4, 1'b0));
    checkOutput("narrow retired after 2", 32'(retired2), 32'd2);
    applyStimulus(8'h56, 1'b0, 1'b0, mk(8'd3, 16'd3, 1'b0, 2'd2, 2'd3, 2'd2, 1, 4, 1'b0));
    applyStimulus(8'h72, 1'b0, 1'b0, mk(8'd4, 16'd4, 1'b0, 2'd2, 2'd1, 2'd3, 1, 4, 1'b0));
    applyStimulus(8'hC0, 1'b0, 1'b0, mk(8'd5, 16'd5, 1'b0, 2'd0, 2'd0, 2'd3, 0, 2, 1'b0));
    applyStimulus(8'h82, 1'b1, 1'b0, mk(8'd7, 16'd6, 1'b1, 2'd0, 2'd1, 2'd1, 0, 3, 1'b0));
    applyStimulus(8'h82, 1'b0, 1'b0, mk(8'd8, 16'd7, 1'b0, 2'd0, 2'd1, 2'd1, 0, 3, 1'b0));

    // Fetch stall: garbage on imem_data while imem_valid is low must not be taken.
    imemData = 8'hA0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall imem_req", 32'(imemReq), 32'd1);
      checkOutput("stall pc", 32'(pc), 32'd8);
      checkOutput("stall busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    applyStimulus(8'hE0, 1'b0, 1'b0, mk(8'd9, 16'd8, 1'b0, 2'd0, 2'd0, 2'd1, 0, 2, 1'b0));

    p = 8'd9; r = 16'd8;
    while (p != 8'd255) begin
      p = p + 8'd2; r = r + 16'd1;
      applyStimulus(8'h82, 1'b1, 1'b0, mk(p, r, 1'b1, 2'd0, 2'd1, 2'd1, 0, 3, 1'b0));
    end
    applyStimulus(8'h82, 1'b1, 1'b0, mk(8'd1, 16'd132, 1'b1, 2'd0, 2'd1, 2'd1, 0, 3, 1'b0));
    p = 8'd1; r = 16'd132;
    while (p != 8'd255) begin
      p = p + 8'd2; r = r + 16'd1;
      applyStimulus(8'h82, 1'b1, 1'b0, mk(p, r, 1'b1, 2'd0, 2'd1, 2'd1, 0, 3, 1'b0));
    end
    applyStimulus(8'hC0, 1'b0, 1'b0, mk(8'd0, 16'd260, 1'b1, 2'd0, 2'd0, 2'd1, 0, 2, 1'b0));
    applyStimulus(8'h0A, 1'b0, 1'b0, mk(8'd1, 16'd261, 1'b0, 2'd1, 2'd1, 2'd0, 1, 4, 1'b0));
    applyStimulus(8'hA0, 1'b0, 1'b0, mk(8'd1, 16'd262, 1'b0, 2'd0, 2'd0, 2'd0, 0, 2, 1'b1));

    repeat (2) @(posedge clk);
    #1;
    checkOutput("halted holds", 32'(halted), 32'd1);
    checkOutput("halted busy", 32'(busy), 32'd0);
    checkOutput("halted imem_req", 32'(imemReq), 32'd0);
    checkOutput("halted pc held", 32'(pc), 32'd1);
    checkOutput("narrow retired saturates", 32'(retired2), 32'd3);
    pulseStartOnce();
    checkOutput("restart pc", 32'(pc), 32'd0);
    checkOutput("restart imem_req", 32'(imemReq), 32'd1);
    checkOutput("restart halted", 32'(halted), 32'd0);
    checkOutput("restart retired kept", 32'(retired), 32'd262);

    // Abort an ADD in WRITEBACK with an asynchronous reset.
    aluZero   = 1'b0;
    imemData  = 8'h0A;
    imemValid = 1'b1;
    @(posedge clk); #1;
    imemValid = 1'b0;
    n = 0;
    while (!regWe && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("writeback reached", 32'(regWe), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort reg_we", 32'(regWe), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort pc", 32'(pc), 32'd0);
    checkOutput("abort retired", 32'(retired), 32'd0);
    checkOutput("abort zero_flag", 32'(zeroFlag), 32'd0);
    checkOutput("abort rd_addr", 32'(rdAddr), 32'd0);
    checkOutput("abort rs_addr", 32'(rsAddr), 32'd0);
    checkOutput("abort narrow retired", 32'(retired2), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("post-abort idle busy", 32'(busy), 32'd0);
      checkOutput("post-abort reg_we", 32'(regWe), 32'd0);
      @(posedge clk); #1;
    end
    pulseStartOnce();
    applyStimulus(8'h0A, 1'b0, 1'b0, mk(8'd1, 16'd1, 1'b0, 2'd1, 2'd1, 2'd0, 1, 4, 1'b0));

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/control_unit_fsm.md
Name: control_unit_fsm

Overview:
- Multicycle control sequencer for the 8-bit datapath. Sits directly upstream of the ALU.
- Fetches an 8-bit instruction from instruction memory and decodes it. Drives the register-file read/write addresses and the 2-bit ALU op code.
- Consumes the ALU zero flag for conditional skip and owns the program counter and the retired-instruction counter.

Parameters:
- PC_WIDTH, 8, program counter width; PC wraps modulo 2^PC_WIDTH.
- CNT_WIDTH, 16, retired-instruction counter width; counter saturates.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin execution from IDLE or HALTED
- imem_valid  input  1  instruction memory returns imem_data this cycle
- imem_data  input  8  instruction word: [7:5] opcode, [4:3] rd, [2:1] rs, [0] unused
- alu_zero  input  1  zero flag from the ALU
- imem_req  output  1  fetch request
- imem_addr  output  PC_WIDTH  fetch address (= pc)
- rd_addr  output  2  register-file read port A / write address
- rs_addr  output  2  register-file read port B
- alu_op  output  2  ALU op code: 00 add, 01 sub, 10 and, 11 or
- reg_we  output  1  register-file write enable
- zero_flag  output  1  registered ALU zero from last EXECUTE
- pc  output  PC_WIDTH  program counter
- busy  output  1  high in FETCH/DECODE/EXECUTE/WRITEBACK
- halted  output  1  high in HALTED
- retired  output  CNT_WIDTH  retired instructions, saturating

Behaviour:
- Reset (async, rst=1): state=IDLE, pc=0, ir=0, rd_addr=0, rs_addr=0, alu_op=00, zero_flag=0, retired=0. All Moore outputs are therefore 0.
- Moore outputs:
  - imem_req=1 only in FETCH; imem_addr=pc.
  - reg_we=1 only in WRITEBACK.
  - busy, halted as listed under Ports.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 BEQ (SUB; skip next instruction if zero), 101 HALT, 110/111 NOP.
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH: wait (any number of cycles) until imem_valid=1. Then latch ir=imem_data and go to DECODE. imem_data is ignored when imem_valid=0.
- DECODE: register rd_addr=ir[4:3], rs_addr=ir[2:1].
  - alu_op = ir[6:5] for ADD..OR, 01 for BEQ; unchanged for HALT/NOP.
  - ALU ops and BEQ -> EXECUTE.
  - HALT -> HALTED; retired+1.
  - NOP -> pc+1, retired+1, FETCH.
- EXECUTE: ALU operands are stable (addresses held from DECODE). At the cycle end, zero_flag <= alu_zero.
  - ALU ops -> WRITEBACK.
  - BEQ: pc <= pc + (alu_zero ? 2 : 1), retired+1, -> FETCH.
- WRITEBACK: reg_we=1 for exactly one cycle; the register file captures the ALU result at rd_addr. pc+1, retired+1, -> FETCH.
- HALTED: hold all registers. start=1 -> pc=0, state FETCH; retired is not cleared.
- rd_addr, rs_addr and alu_op change only in DECODE; they are stable from EXECUTE through WRITEBACK.
- Latency with imem_valid high in the first FETCH cycle: ALU op 4 cycles, BEQ 3, NOP 2, HALT 2 (FETCH to FETCH/HALTED).
- PC arithmetic is modulo 2^PC_WIDTH. pc=255 with skip -> 1; pc=255 +1 -> 0.
- retired saturates at 2^CNT_WIDTH-1 and never wraps.
- start is ignored while busy.
- rst asserted mid-instruction immediately aborts the instruction: no reg_we pulse afterwards, and registers return to reset values.

Test Plan:
- Reset then start, imem_valid held 1, instr 0x0A (ADD rd=1 rs=1) -> imem_req 1 cycle; rd_addr=1, rs_addr=1, alu_op=00 from EXECUTE; reg_we single pulse in cycle 4; pc=1, retired=1.
- BEQ 0x82 at pc=5 with alu_zero=1 -> pc=7, no reg_we, zero_flag=1. Repeat with alu_zero=0 -> pc=6, zero_flag=0.
- FETCH with imem_valid low for 3 cycles -> imem_req stays high, state holds, pc unchanged. Instruction latched on the 4th cycle.
- HALT 0xA0 -> halted=1, busy=0, retired+1; start ignored while busy earlier; start in HALTED -> pc=0, FETCH.
- pc=255 executing BEQ with zero=1 -> pc=1; NOP at pc=255 -> pc=0. retired preloaded near max (CNT_WIDTH=2) -> saturates at 3.
- rst pulsed during WRITEBACK -> reg_we drops immediately; all outputs are reset values; IDLE until start.
